// File: rtl/key_165_pkg.sv
// Shared definitions for the 74HC165 chain reader: state encoding,
// default timing constants and a scan-length helper.
package key_165_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

    localparam int CLK_DIV_DEF      = 4;
    localparam int SCAN_CNT_MAX_DEF = 999_999;

    // Cycles from the start cycle up to and including the data_valid cycle.
    function automatic int scan_len(input int clk_div, input int data_w);
        return 2 * clk_div * (data_w + 1) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_165_scan.sv
// 74HC165 chain reader: periodic or requested load, MSB-first serial
// capture, parallel word out with one-cycle valid and change pulses.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | chain inhibited, waiting for scan_tick or scan_req
//  LOAD   | SH/LD low for 2*CLK_DIV cycles, latching the parallel pins
//  SHIFT  | DATA_W shift-clock periods; sample qh_s at end of low half
//  DONE   | one cycle: publish data, pulse data_valid / data_chg
module key_165_scan
    import key_165_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int SCAN_CNT_MAX = SCAN_CNT_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              qh,
    input  logic              scan_req,
    output logic              sh_ld,
    output logic              shcp,
    output logic              clk_inh,
    output logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              data_chg
);

    localparam int TMR_W = $clog2(SCAN_CNT_MAX + 1);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_CNT_MAX);

    logic              qh_s;
    logic [TMR_W-1:0]  tmr_cnt;
    logic              scan_tick;

    state_t            state, state_nxt;
    logic [7:0]        div_cnt, div_nxt;
    logic              half_hi, half_hi_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic              div_end;
    logic              shift_en;

    logic [DATA_W-1:0] sreg;

    logic              sh_ld_nxt;
    logic              shcp_nxt;
    logic              clk_inh_nxt;
    logic              busy_nxt;
    logic              publish;

    sync_2ff u_sync_qh (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (qh),
        .q     (qh_s)
    );

    assign scan_tick = (tmr_cnt == TMR_LAST);
    assign div_end   = (div_cnt == DIV_LAST);

    // Free-running scan timer, 0..SCAN_CNT_MAX then wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmr_cnt <= '0;
        end else if (scan_tick) begin
            tmr_cnt <= '0;
        end else begin
            tmr_cnt <= tmr_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and pin logic; pins are computed from the next
    // state so the registered outputs line up with the state register.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        half_hi_nxt = half_hi;
        bit_nxt     = bit_cnt;
        shift_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                div_nxt     = '0;
                half_hi_nxt = 1'b0;
                bit_nxt     = '0;
                if (scan_tick || scan_req) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (div_end) begin
                    div_nxt     = '0;
                    half_hi_nxt = ~half_hi;
                    if (half_hi) begin
                        state_nxt = ST_SHIFT;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    div_nxt     = '0;
                    half_hi_nxt = ~half_hi;
                    if (!half_hi) begin
                        // qh_s has had the whole low half to settle
                        shift_en = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        sh_ld_nxt   = (state_nxt != ST_LOAD);
        clk_inh_nxt = (state_nxt != ST_SHIFT);
        shcp_nxt    = (state_nxt == ST_SHIFT) && half_hi_nxt;
        busy_nxt    = (state_nxt != ST_IDLE);
        publish     = (state_nxt == ST_DONE);
    end

    // Half-period divider, half-phase flag and bit counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
            half_hi <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= div_nxt;
            half_hi <= half_hi_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    // Capture shift register, MSB first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sreg <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[DATA_W-2:0], qh_s};
        end
    end

    // Registered chain pins and busy, glitch-free by construction.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_ld   <= 1'b1;
            shcp    <= 1'b0;
            clk_inh <= 1'b1;
            busy    <= 1'b0;
        end else begin
            sh_ld   <= sh_ld_nxt;
            shcp    <= shcp_nxt;
            clk_inh <= clk_inh_nxt;
            busy    <= busy_nxt;
        end
    end

    // Publish the finished word; change flag compares against the old word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            data_chg   <= 1'b0;
        end else begin
            data_valid <= publish;
            data_chg   <= publish && (sreg != data);
            if (publish) begin
                data <= sreg;
            end
        end
    end

`ifndef SYNTHESIS
    // A scan plus the return to IDLE must fit inside one timer period,
    // otherwise timed scans would be silently dropped.
    always @(posedge sys_clk) begin
        if (sys_rst_n) begin
            assert (SCAN_CNT_MAX + 1 > scan_len(CLK_DIV, DATA_W) + 1)
                else $error("key_165_scan: SCAN_CNT_MAX too small for one scan");
            assert (CLK_DIV >= 3 && CLK_DIV <= 255)
                else $error("key_165_scan: CLK_DIV out of range");
            assert (DATA_W >= 8 && (DATA_W % 8) == 0)
                else $error("key_165_scan: DATA_W must be a multiple of 8");
        end
    end
`endif

endmodule
